// File: rtl/srt4_pkg.sv
// srt4_pkg: shared definitions for the SRT-4 divider datapath.
// Holds the signed radix-4 digit encoding used by the control unit's
// lookup table and the quotient accumulator FSM states.
package srt4_pkg;

    localparam int unsigned DIGIT_W = 3;

    // Signed digit codes, identical to the control unit's lookup table
    localparam logic [DIGIT_W-1:0] D_0  = 3'b000;
    localparam logic [DIGIT_W-1:0] D_P1 = 3'b001;
    localparam logic [DIGIT_W-1:0] D_P2 = 3'b010;
    localparam logic [DIGIT_W-1:0] D_N1 = 3'b101;
    localparam logic [DIGIT_W-1:0] D_N2 = 3'b110;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        CORRECT = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/srt4_otf_step.sv
// srt4_otf_step: one step of on-the-fly conversion of a signed radix-4 digit.
// Ports:
//   q, qm        current quotient and quotient-minus-one registers
//   digit        signed digit code (see srt4_pkg)
//   q_next_c     next Q value (combinational)
//   qm_next_c    next QM value (combinational)
//   illegal_c    digit code is not one of the five legal codes
module srt4_otf_step
    import srt4_pkg::*;
#(
    parameter int unsigned QW = 8
) (
    input  logic [QW-1:0]      q,
    input  logic [QW-1:0]      qm,
    input  logic [DIGIT_W-1:0] digit,
    output logic [QW-1:0]      q_next_c,
    output logic [QW-1:0]      qm_next_c,
    output logic               illegal_c
);

    // Digit as 3-bit two's complement; illegal codes behave as zero
    logic [2:0] d;
    logic       d_neg;
    logic       d_pos;
    logic [2:0] d_plus3;

    always_comb begin
        d         = 3'b000;
        illegal_c = 1'b0;
        case (digit)
            D_0:     d = 3'b000;
            D_P1:    d = 3'b001;
            D_P2:    d = 3'b010;
            D_N1:    d = 3'b111;
            D_N2:    d = 3'b110;
            default: illegal_c = 1'b1;
        endcase
    end

    assign d_neg   = d[2];
    assign d_pos   = !d[2] && (d != 3'b000);
    // (d-1) mod 4 == (d+3) mod 4 and (4+d) mod 4 == d mod 4, so one
    // appended pair per register covers both source choices
    assign d_plus3 = d + 3'd3;

    assign q_next_c  = {(d_neg ? qm[QW-3:0] : q[QW-3:0]), d[1:0]};
    assign qm_next_c = {(d_pos ? q[QW-3:0] : qm[QW-3:0]), d_plus3[1:0]};

endmodule

// File: rtl/srt4_quotient_accumulator.sv
// srt4_quotient_accumulator: converts the SRT-4 digit stream into a binary
// quotient via Q/QM on-the-fly conversion, applies the final Q-1 correction
// for a negative remainder and hands the result downstream with valid/ready.
// Optional build macro SRT4_QACC_REM_FIX_EN adds remainder correction
// (ports rem_in, div_in, remainder).
// Ports:
//   clk, rst_b     clock, synchronous active-low reset
//   start          clears the accumulator and begins a division (any state)
//   digit_valid    digit strobe, one per iteration
//   digit          signed digit code
//   finish         remainder sign is final; rem_neg sampled with it
//   rem_neg        sign of the final partial remainder
//   quotient       corrected quotient, held while out_valid
//   out_valid      result valid until out_ready
//   out_ready      downstream accept
//   busy           high in ACCUM and CORRECT
//   err            sticky protocol/encoding error, cleared by start
//   rem_in         (optional) signed partial remainder, sampled with finish
//   div_in         (optional) normalized divisor, sampled with start
//   remainder      (optional) corrected remainder
module srt4_quotient_accumulator
    import srt4_pkg::*;
#(
    parameter  int unsigned DIGITS = 4,
    localparam int unsigned QW     = 2 * DIGITS
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               start,
    input  logic               digit_valid,
    input  logic [DIGIT_W-1:0] digit,
    input  logic               finish,
    input  logic               rem_neg,
`ifdef SRT4_QACC_REM_FIX_EN
    input  logic [QW:0]        rem_in,
    input  logic [QW-1:0]      div_in,
    output logic [QW-1:0]      remainder,
`endif
    output logic [QW-1:0]      quotient,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               err
);

    localparam int unsigned CW = $clog2(DIGITS + 1);

    state_t          state;
    logic [QW-1:0]   q;
    logic [QW-1:0]   qm;
    logic [CW-1:0]   count;
    logic            rem_neg_q;

    logic [QW-1:0]   q_step;
    logic [QW-1:0]   qm_step;
    logic            illegal;
    logic            digit_take;
    logic [CW-1:0]   count_after;
    logic            finish_ok;

    srt4_otf_step #(
        .QW (QW)
    ) u_otf_step (
        .q         (q),
        .qm        (qm),
        .digit     (digit),
        .q_next_c  (q_step),
        .qm_next_c (qm_step),
        .illegal_c (illegal)
    );

    // A digit is only consumed while the count is not yet full; finish is
    // judged against the count including a same-cycle digit
    assign digit_take  = digit_valid && (count != CW'(DIGITS));
    assign count_after = count + CW'(digit_take);
    assign finish_ok   = (count_after == CW'(DIGITS));

`ifdef SRT4_QACC_REM_FIX_EN
    logic [QW:0]   rem_q;
    logic [QW-1:0] div_q;
    logic [QW:0]   rem_fix;
    logic          rem_fix_sign_unused;

    // Restoring add for a negative remainder; the sign bit is dropped
    assign rem_fix             = rem_neg_q ? (rem_q + {1'b0, div_q}) : rem_q;
    assign rem_fix_sign_unused = rem_fix[QW];
`endif

    // Control FSM, counter and result registers
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state     <= IDLE;
            q         <= '0;
            qm        <= '1;
            count     <= '0;
            rem_neg_q <= 1'b0;
            quotient  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
`ifdef SRT4_QACC_REM_FIX_EN
            rem_q     <= '0;
            div_q     <= '0;
            remainder <= '0;
`endif
        end else if (start) begin
            state     <= ACCUM;
            q         <= '0;
            qm        <= '1;
            count     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b1;
            err       <= 1'b0;
`ifdef SRT4_QACC_REM_FIX_EN
            div_q     <= div_in;
`endif
        end else begin
            case (state)
                IDLE: begin
                end
                ACCUM: begin
                    if (digit_valid) begin
                        if (digit_take) begin
                            q     <= q_step;
                            qm    <= qm_step;
                            count <= count_after;
                            if (illegal) begin
                                err <= 1'b1;
                            end
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    if (finish) begin
                        if (finish_ok) begin
                            rem_neg_q <= rem_neg;
                            state     <= CORRECT;
`ifdef SRT4_QACC_REM_FIX_EN
                            rem_q     <= rem_in;
`endif
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                CORRECT: begin
                    // QM already equals Q-1, so correction is a register select
                    quotient  <= rem_neg_q ? qm : q;
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= DONE;
`ifdef SRT4_QACC_REM_FIX_EN
                    remainder <= rem_fix[QW-1:0];
`endif
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_srt4_quotient_accumulator.sv
// tb_srt4_quotient_accumulator: self-checking bench for the quotient
// accumulator; expected quotients come from an arithmetic digit-sum model
// and are queued when a division is driven, then compared on out_valid.
module tb_srt4_quotient_accumulator;
    import srt4_pkg::*;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned QW     = 2 * DIGITS;

    logic          clk = 1'b0;
    logic          rst_b;
    logic          start;
    logic          digit_valid;
    logic [2:0]    digit;
    logic          finish;
    logic          rem_neg;
    logic [QW-1:0] quotient;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          err;
`ifdef SRT4_QACC_REM_FIX_EN
    logic [QW:0]   rem_in;
    logic [QW-1:0] div_in;
    logic [QW-1:0] remainder;
`endif

    int            checks = 0;
    int            errors = 0;
    logic [QW-1:0] exp_q[$];

    always #5 clk = ~clk;

    srt4_quotient_accumulator #(
        .DIGITS (DIGITS)
    ) dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .start       (start),
        .digit_valid (digit_valid),
        .digit       (digit),
        .finish      (finish),
        .rem_neg     (rem_neg),
`ifdef SRT4_QACC_REM_FIX_EN
        .rem_in      (rem_in),
        .div_in      (div_in),
        .remainder   (remainder),
`endif
        .quotient    (quotient),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .err         (err)
    );

    function automatic int code_val(input logic [2:0] c);
        case (c)
            D_P1:    return 1;
            D_P2:    return 2;
            D_N1:    return -1;
            D_N2:    return -2;
            default: return 0;
        endcase
    endfunction

    // Quotient = sum of digits weighted by powers of 4, minus one if negative
    function automatic logic [QW-1:0] model_q(input logic [11:0] codes, input bit rn);
        int acc = 0;
        for (int i = 0; i < 4; i++) begin
            acc = acc * 4 + code_val(codes[11-3*i -: 3]);
        end
        acc = acc - int'(rn);
        return QW'(acc);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic drive_digit(input logic [2:0] c, input bit fin, input bit rn);
        digit_valid = 1'b1;
        digit       = c;
        finish      = fin;
        rem_neg     = rn;
        tick();
        digit_valid = 1'b0;
        digit       = 3'b000;
        finish      = 1'b0;
        rem_neg     = 1'b0;
    endtask

    task automatic drive_finish(input bit rn);
        finish  = 1'b1;
        rem_neg = rn;
        tick();
        finish  = 1'b0;
        rem_neg = 1'b0;
    endtask

    // Full division: start, four digits, finish; checks the two-cycle latency
    task automatic run_op(input string name, input logic [11:0] codes, input bit rn,
                          input bit same_cycle);
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            drive_digit(codes[11-3*i -: 3], same_cycle && (i == 3), rn);
        end
        if (!same_cycle) begin
            drive_finish(rn);
        end
        exp_q.push_back(model_q(codes, rn));
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_latency_early: out_valid got %b want 0", name, out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_latency: out_valid got %b want 1", name, out_valid);
        end
    endtask

    // Wait for out_valid, compare against the scoreboard, then accept
    task automatic collect(input string name, input logic exp_err);
        logic [QW-1:0] exp;
        int n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: out_valid got %b want 1", name, out_valid);
        end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_scoreboard: got quotient %0h want none queued", name, quotient);
        end else begin
            exp = exp_q.pop_front();
            checks++;
            if (quotient !== exp) begin
                errors++;
                $display("FAIL %s_quotient: got %0h want %0h", name, quotient, exp);
            end
            checks++;
            if (err !== exp_err) begin
                errors++;
                $display("FAIL %s_err: got %b want %b", name, err, exp_err);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_accept: out_valid=%b busy=%b want 0 0", name, out_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        tick();
        tick();
        checks++;
        if (quotient !== '0 || out_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset: q=%0h ov=%b busy=%b err=%b want 0 0 0 0",
                     quotient, out_valid, busy, err);
        end
        rst_b = 1'b1;
        tick();
    endtask

    task automatic test_idle_ignore();
        drive_digit(D_P1, 1'b1, 1'b0);
        checks++;
        if (busy !== 1'b0 || err !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore: busy=%b err=%b ov=%b want 0 0 0", busy, err, out_valid);
        end
    endtask

    task automatic test_basic();
        run_op("basic_pos", {D_P1, D_0, D_N1, D_P2}, 1'b0, 1'b0);
        collect("basic_pos", 1'b0);
        run_op("basic_neg", {D_P1, D_0, D_N1, D_P2}, 1'b1, 1'b0);
        collect("basic_neg", 1'b0);
    endtask

    task automatic test_same_cycle_finish();
        run_op("same_cycle", {D_P2, D_N2, D_0, D_P1}, 1'b0, 1'b1);
        collect("same_cycle", 1'b0);
        run_op("negative_q", {D_N1, D_0, D_0, D_0}, 1'b0, 1'b1);
        collect("negative_q", 1'b0);
    endtask

    task automatic test_early_finish();
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            drive_digit(D_P1, 1'b0, 1'b0);
        end
        drive_finish(1'b0);
        checks++;
        if (err !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL early_finish: err=%b busy=%b ov=%b want 1 1 0", err, busy, out_valid);
        end
        drive_digit(D_P1, 1'b1, 1'b0);
        exp_q.push_back(model_q({D_P1, D_P1, D_P1, D_P1}, 1'b0));
        collect("early_finish", 1'b1);
        pulse_start();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL early_finish_clear: err got %b want 0", err);
        end
    endtask

    task automatic test_extra_digit();
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            drive_digit(D_P1, 1'b0, 1'b0);
        end
        drive_digit(D_N2, 1'b0, 1'b0);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL extra_digit_err: err got %b want 1", err);
        end
        drive_finish(1'b0);
        exp_q.push_back(model_q({D_P1, D_P1, D_P1, D_P1}, 1'b0));
        collect("extra_digit", 1'b1);
    endtask

    task automatic test_illegal_and_restart();
        run_op("illegal", {D_P1, 3'b011, D_P1, D_0}, 1'b0, 1'b0);
        collect("illegal", 1'b1);
        pulse_start();
        drive_digit(3'b011, 1'b0, 1'b0);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL illegal_err: err got %b want 1", err);
        end
        drive_digit(D_P1, 1'b0, 1'b0);
        pulse_start();
        checks++;
        if (err !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL restart: err=%b busy=%b ov=%b want 0 1 0", err, busy, out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            drive_digit(D_P2, (i == 3), 1'b1);
        end
        exp_q.push_back(model_q({D_P2, D_P2, D_P2, D_P2}, 1'b1));
        collect("restart", 1'b0);
    endtask

    task automatic test_backpressure();
        logic [QW-1:0] held;
        run_op("backpressure", {D_N2, D_P2, D_N1, D_P1}, 1'b1, 1'b0);
        held = exp_q[0];
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || quotient !== held) begin
                errors++;
                $display("FAIL backpressure_hold%0d: ov=%b q=%0h want 1 %0h",
                         i, out_valid, quotient, held);
            end
            tick();
        end
        collect("backpressure", 1'b0);
    endtask

    task automatic test_start_in_done();
        run_op("start_done", {D_P1, D_P1, D_0, D_0}, 1'b0, 1'b0);
        void'(exp_q.pop_front());
        pulse_start();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_in_done: ov=%b busy=%b want 0 1", out_valid, busy);
        end
    endtask

    task automatic test_reset_mid();
        drive_digit(3'b111, 1'b0, 1'b0);
        rst_b = 1'b0;
        tick();
        checks++;
        if (quotient !== '0 || out_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: q=%0h ov=%b busy=%b err=%b want 0 0 0 0",
                     quotient, out_valid, busy, err);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_beats_start: busy got %b want 0", busy);
        end
        rst_b = 1'b1;
        tick();
    endtask

`ifdef SRT4_QACC_REM_FIX_EN
    task automatic test_rem_fix();
        div_in = 8'h80;
        rem_in = 9'h1FD;
        run_op("rem_fix", {D_P1, D_0, D_0, D_0}, 1'b1, 1'b0);
        checks++;
        if (remainder !== 8'h7D) begin
            errors++;
            $display("FAIL rem_fix: remainder got %0h want 7d", remainder);
        end
        collect("rem_fix", 1'b0);
    endtask
`endif

    initial begin
        rst_b       = 1'b0;
        start       = 1'b0;
        digit_valid = 1'b0;
        digit       = 3'b000;
        finish      = 1'b0;
        rem_neg     = 1'b0;
        out_ready   = 1'b0;
`ifdef SRT4_QACC_REM_FIX_EN
        rem_in      = '0;
        div_in      = '0;
`endif
        test_reset();
        test_idle_ignore();
        test_basic();
        test_same_cycle_finish();
        test_early_finish();
        test_extra_digit();
        test_illegal_and_restart();
        test_backpressure();
        test_start_in_done();
        test_reset_mid();
`ifdef SRT4_QACC_REM_FIX_EN
        test_rem_fix();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
